basket_controller: RTL and testbench
====================================

Name: basket_controller

Overview:
- Sequences the shopping-basket storage for the sale terminal.
- Accepts add, cancel, cursor and clear commands from the main state machine (Quantity and BasketEdit states) and keeps a compacted list of (product ID, quantity) entries.
- Merges repeat products, removes the highlighted entry with multi-cycle compaction, and tracks the running total quantity.
- Its read port feeds the VGA/text display.

Parameters:
- MAX_ITEMS, 8, number of basket slots (power of 2, ≥2).
- IDX_W, 3, log2(MAX_ITEMS).
- MAX_QTY, 7, per-entry quantity saturation value (fits 3 bits).
- TOT_W, 6, width of total quantity (must hold MAX_ITEMS*MAX_QTY).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- add_req  in  1  one-cycle pulse: add add_id with add_qty
- add_id  in  4  product ID (0..15)
- add_qty  in  3  quantity 1..4 (0 treated as no-op add, err pulse)
- cancel_req  in  1  one-cycle pulse: remove entry at cursor
- cur_up  in  1  pulse: cursor-1
- cur_down  in  1  pulse: cursor+1
- clear_req  in  1  pulse: empty basket
- rd_idx  in  IDX_W  display read index
- rd_id  out  4  ID at rd_idx (combinational read)
- rd_qty  out  3  qty at rd_idx, 0 if rd_idx ≥ count
- count  out  IDX_W+1  valid entries
- cursor  out  IDX_W  highlighted entry
- total_qty  out  TOT_W  sum of all entry quantities
- busy  out  1  high while not in IDLE
- full  out  1  count == MAX_ITEMS
- err  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset: all entries id=0/qty=0, count=0, cursor=0, total_qty=0, err=0, state IDLE (busy=0).
- Commands are sampled only in IDLE; while busy, all request inputs are ignored (no queuing).
- Same-cycle priority: clear > cancel > add > cur_up > cur_down. Lower-priority requests in that cycle are dropped.
- States: IDLE, SEARCH, SHIFT.
- Clear (IDLE): takes effect in one cycle. count, cursor and total_qty become 0 and all qty fields become 0. Stays IDLE.
- Cursor:
  - cur_up at cursor=0 holds at 0.
  - cur_down holds at count-1 (at 0 when count=0).
  - Moves take effect in one cycle.
- Add:
  - Accepted in cycle T: latch id/qty, scan index s=0, go to SEARCH.
  - SEARCH examines one index per cycle, starting at T+1.
  - If s<count and entry[s].id==add_id: qty = min(qty+add_qty, MAX_QTY), total_qty increases by the applied delta, go to IDLE.
  - If s==count and not full: write entry[count], count+1, total_qty += add_qty, go to IDLE.
  - If s==count and full: err pulse, no change, go to IDLE.
  - Match at index k completes at T+1+k. Append completes at T+1+count. busy is high from T+1 through the completion cycle.
  - add_qty=0: err pulse in T, stays IDLE.
- Cancel:
  - count=0: err pulse, stays IDLE.
  - Otherwise, in T: total_qty -= entry[cursor].qty, s=cursor, go to SHIFT.
  - SHIFT, s<count-1: entry[s] ← entry[s+1], s+1.
  - SHIFT, s==count-1: clear entry[s], count-1. If cursor==new count and count>0, cursor-1. Go to IDLE.
  - Takes count-cursor cycles after T.
- total_qty arithmetic: unsigned TOT_W. Never wraps, by construction of the saturation rules.
- full is combinational from count.
- Reset asserted mid-SEARCH/SHIFT aborts the operation and returns to the reset values.
- The read port is independent of state; during SHIFT the display may show transient duplicates.

Test Plan:
- Reset, then add (id 5, qty 3) → busy for 1 cycle; count=1, entry0=(5,3), total_qty=3.
- Adds of ids 5,9,2 (qty 2 each), then add id 2 qty 4 → match at index 2 completes at T+3; entry2 qty=6; count=3; total_qty=10.
- Add id 9 qty 4 twice onto qty 2 → qty saturates at 7; total_qty reflects applied delta only (+4 then +1).
- Entries A,B,C,D; cursor_down×1; cancel → after 3 cycles list=A,C,D, count=3, cursor=1, total_qty reduced by B.qty. Cancel at cursor=2 (last) → cursor becomes 1.
- Fill 8 distinct ids, then add new id → err pulse 1 cycle, full=1, no change. Cancel with count=0 → err pulse.
- clear_req+add_req same cycle → clear wins, count=0. RESET asserted mid-SHIFT → all outputs at reset values immediately.

Source files
------------

// File: rtl/basket_controller.sv
// rtl/basket_controller.sv - compacted shopping-basket storage with merge, cancel-compaction and running total
module basket_controller #(
  parameter int MAX_ITEMS = 8,
  parameter int IDX_W     = 3,
  parameter int MAX_QTY   = 7,
  parameter int TOT_W     = 6
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             add_req,
  input  logic [3:0]       add_id,
  input  logic [2:0]       add_qty,
  input  logic             cancel_req,
  input  logic             cur_up,
  input  logic             cur_down,
  input  logic             clear_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [3:0]       rd_id,
  output logic [2:0]       rd_qty,
  output logic [IDX_W:0]   count,
  output logic [IDX_W-1:0] cursor,
  output logic [TOT_W-1:0] total_qty,
  output logic             busy,
  output logic             full,
  output logic             err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(MAX_ITEMS);
  localparam logic [3:0]     QTY_SAT = 4'(MAX_QTY);

  logic [3:0]       id_mem  [MAX_ITEMS];
  logic [2:0]       qty_mem [MAX_ITEMS];
  logic [1:0]       state;
  logic [IDX_W:0]   scan;
  logic [3:0]       lat_id;
  logic [2:0]       lat_qty;
  logic [IDX_W:0]   cnt;
  logic [IDX_W-1:0] cur;
  logic [TOT_W-1:0] tot;
  logic             err_r;

  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] scan_nxt;
  logic [IDX_W:0]   cnt_m1;
  logic [3:0]       qty_sum;
  logic [2:0]       qty_new;
  logic [2:0]       qty_delta;

  always_comb begin
    scan_idx  = scan[IDX_W-1:0];
    scan_nxt  = scan_idx + IDX_W'(1);
    cnt_m1    = cnt - (IDX_W+1)'(1);
    qty_sum   = {1'b0, qty_mem[scan_idx]} + {1'b0, lat_qty};
    // Merge saturates; only the quantity actually added reaches the total
    qty_new   = (qty_sum > QTY_SAT) ? QTY_SAT[2:0] : qty_sum[2:0];
    qty_delta = qty_new - qty_mem[scan_idx];
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < MAX_ITEMS; i++) begin
        id_mem[i]  <= 4'd0;
        qty_mem[i] <= 3'd0;
      end
      state   <= ST_IDLE;
      scan    <= '0;
      lat_id  <= 4'd0;
      lat_qty <= 3'd0;
      cnt     <= '0;
      cur     <= '0;
      tot     <= '0;
      err_r   <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            cnt <= '0;
            cur <= '0;
            tot <= '0;
            for (int i = 0; i < MAX_ITEMS; i++) qty_mem[i] <= 3'd0;
          end else if (cancel_req) begin
            if (cnt == '0) begin
              err_r <= 1'b1;
            end else begin
              tot   <= tot - TOT_W'(qty_mem[cur]);
              scan  <= {1'b0, cur};
              state <= ST_SHIFT;
            end
          end else if (add_req) begin
            if (add_qty == 3'd0) begin
              err_r <= 1'b1;
            end else begin
              lat_id  <= add_id;
              lat_qty <= add_qty;
              scan    <= '0;
              state   <= ST_SEARCH;
            end
          end else if (cur_up) begin
            if (cur != '0) cur <= cur - IDX_W'(1);
          end else if (cur_down) begin
            if (({1'b0, cur} + (IDX_W+1)'(1)) < cnt) cur <= cur + IDX_W'(1);
          end
        end
        ST_SEARCH: begin
          if (scan == cnt) begin
            if (cnt == CNT_MAX) begin
              err_r <= 1'b1;
            end else begin
              id_mem[cnt[IDX_W-1:0]]  <= lat_id;
              qty_mem[cnt[IDX_W-1:0]] <= lat_qty;
              cnt <= cnt + (IDX_W+1)'(1);
              tot <= tot + TOT_W'(lat_qty);
            end
            state <= ST_IDLE;
          end else if (id_mem[scan_idx] == lat_id) begin
            qty_mem[scan_idx] <= qty_new;
            tot   <= tot + TOT_W'(qty_delta);
            state <= ST_IDLE;
          end else begin
            scan <= scan + (IDX_W+1)'(1);
          end
        end
        ST_SHIFT: begin
          if (scan < cnt_m1) begin
            id_mem[scan_idx]  <= id_mem[scan_nxt];
            qty_mem[scan_idx] <= qty_mem[scan_nxt];
            scan <= scan + (IDX_W+1)'(1);
          end else begin
            id_mem[scan_idx]  <= 4'd0;
            qty_mem[scan_idx] <= 3'd0;
            cnt <= cnt_m1;
            // Removing the last entry pulls the highlight back onto the new tail
            if (cnt_m1 != '0 && {1'b0, cur} == cnt_m1) cur <= cur - IDX_W'(1);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd_id     = id_mem[rd_idx];
  assign rd_qty    = ({1'b0, rd_idx} < cnt) ? qty_mem[rd_idx] : 3'd0;
  assign count     = cnt;
  assign cursor    = cur;
  assign total_qty = tot;
  assign busy      = (state != ST_IDLE);
  assign full      = (cnt == CNT_MAX);
  assign err       = err_r;

endmodule

// File: tb/tb_basket_controller.sv
// tb/tb_basket_controller.sv - directed vector bench for basket_controller
module tb_basket_controller;

  localparam int OP_ADD    = 0;
  localparam int OP_CANCEL = 1;
  localparam int OP_UP     = 2;
  localparam int OP_DOWN   = 3;
  localparam int OP_CLEAR  = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       add_req, cancel_req, cur_up, cur_down, clear_req;
  logic [3:0] add_id;
  logic [2:0] add_qty;
  logic [2:0] rd_idx;
  logic [3:0] rd_id;
  logic [2:0] rd_qty;
  logic [3:0] count;
  logic [2:0] cursor;
  logic [5:0] total_qty;
  logic       busy, full, err;

  always #5 CLOCK_50 = ~CLOCK_50;

  basket_controller dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET),
    .add_req(add_req), .add_id(add_id), .add_qty(add_qty),
    .cancel_req(cancel_req), .cur_up(cur_up), .cur_down(cur_down),
    .clear_req(clear_req), .rd_idx(rd_idx), .rd_id(rd_id), .rd_qty(rd_qty),
    .count(count), .cursor(cursor), .total_qty(total_qty),
    .busy(busy), .full(full), .err(err)
  );

  typedef struct {
    int op; int id; int qty;
    int e_cnt; int e_tot; int e_cur; int e_err; int e_cyc;
    int ridx; int e_rid; int e_rqty; int chk_id;
  } vec_t;

  vec_t vt[20];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  // Pulse one command, then count busy cycles until IDLE and note any err pulse
  task automatic do_cmd(input int op, input int id, input int qty, output int cyc, output int errs);
    add_id  = 4'(id);
    add_qty = 3'(qty);
    case (op)
      OP_ADD:    add_req    = 1'b1;
      OP_CANCEL: cancel_req = 1'b1;
      OP_UP:     cur_up     = 1'b1;
      OP_DOWN:   cur_down   = 1'b1;
      default:   clear_req  = 1'b1;
    endcase
    tick;
    add_req = 0; cancel_req = 0; cur_up = 0; cur_down = 0; clear_req = 0;
    errs = int'(err);
    cyc  = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick;
      if (err) errs = 1;
    end
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  initial begin
    int cyc, errs;
    RESET = 1'b1;
    add_req = 0; cancel_req = 0; cur_up = 0; cur_down = 0; clear_req = 0;
    add_id = 4'd0; add_qty = 3'd0; rd_idx = 3'd0;

    //          op         id qty cnt tot cur err cyc ridx rid rqty chkid
    vt[0]  = '{OP_ADD,    5, 3,  1,  3,  0,  0,  1,  0,   5,  3,  1};
    vt[1]  = '{OP_CLEAR,  0, 0,  0,  0,  0,  0,  0,  0,   0,  0,  0};
    vt[2]  = '{OP_ADD,    5, 2,  1,  2,  0,  0,  1,  0,   5,  2,  1};
    vt[3]  = '{OP_ADD,    9, 2,  2,  4,  0,  0,  2,  1,   9,  2,  1};
    vt[4]  = '{OP_ADD,    2, 2,  3,  6,  0,  0,  3,  2,   2,  2,  1};
    vt[5]  = '{OP_ADD,    2, 4,  3, 10,  0,  0,  3,  2,   2,  6,  1};
    vt[6]  = '{OP_ADD,    9, 4,  3, 14,  0,  0,  2,  1,   9,  6,  1};
    vt[7]  = '{OP_ADD,    9, 4,  3, 15,  0,  0,  2,  1,   9,  7,  1};
    vt[8]  = '{OP_ADD,    3, 0,  3, 15,  0,  1,  0,  1,   9,  7,  1};
    vt[9]  = '{OP_ADD,    4, 1,  4, 16,  0,  0,  4,  3,   4,  1,  1};
    vt[10] = '{OP_DOWN,   0, 0,  4, 16,  1,  0,  0,  0,   5,  2,  1};
    vt[11] = '{OP_CANCEL, 0, 0,  3,  9,  1,  0,  3,  1,   2,  6,  1};
    vt[12] = '{OP_DOWN,   0, 0,  3,  9,  2,  0,  0,  2,   4,  1,  1};
    vt[13] = '{OP_DOWN,   0, 0,  3,  9,  2,  0,  0,  3,   0,  0,  0};
    vt[14] = '{OP_CANCEL, 0, 0,  2,  8,  1,  0,  1,  2,   0,  0,  0};
    vt[15] = '{OP_UP,     0, 0,  2,  8,  0,  0,  0,  1,   2,  6,  1};
    vt[16] = '{OP_UP,     0, 0,  2,  8,  0,  0,  0,  0,   5,  2,  1};
    vt[17] = '{OP_CLEAR,  0, 0,  0,  0,  0,  0,  0,  0,   0,  0,  0};
    vt[18] = '{OP_CANCEL, 0, 0,  0,  0,  0,  1,  0,  0,   0,  0,  0};
    vt[19] = '{OP_DOWN,   0, 0,  0,  0,  0,  0,  0,  1,   0,  0,  0};

    repeat (2) @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_total", int'(total_qty), 0);
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rd_qty", int'(rd_qty), 0);

    for (int i = 0; i < 20; i++) begin
      do_cmd(vt[i].op, vt[i].id, vt[i].qty, cyc, errs);
      rd_idx = 3'(vt[i].ridx);
      #1;
      chk($sformatf("v%0d_count", i), int'(count), vt[i].e_cnt);
      chk($sformatf("v%0d_total", i), int'(total_qty), vt[i].e_tot);
      chk($sformatf("v%0d_cursor", i), int'(cursor), vt[i].e_cur);
      chk($sformatf("v%0d_err", i), errs, vt[i].e_err);
      chk($sformatf("v%0d_busy_cycles", i), cyc, vt[i].e_cyc);
      chk($sformatf("v%0d_full", i), int'(full), 0);
      chk($sformatf("v%0d_rd_qty", i), int'(rd_qty), vt[i].e_rqty);
      if (vt[i].chk_id != 0) chk($sformatf("v%0d_rd_id", i), int'(rd_id), vt[i].e_rid);
      tick;
      chk($sformatf("v%0d_err_low", i), int'(err), 0);
    end

    for (int i = 0; i < 8; i++) begin
      do_cmd(OP_ADD, i, 1, cyc, errs);
      chk($sformatf("fill%0d_count", i), int'(count), i + 1);
      chk($sformatf("fill%0d_cycles", i), cyc, i + 1);
    end
    chk("fill_full", int'(full), 1);
    do_cmd(OP_ADD, 12, 1, cyc, errs);
    chk("full_add_err", errs, 1);
    chk("full_add_cycles", cyc, 9);
    chk("full_add_count", int'(count), 8);
    chk("full_add_total", int'(total_qty), 8);
    tick;
    chk("full_add_err_pulse", int'(err), 0);
    do_cmd(OP_ADD, 7, 3, cyc, errs);
    rd_idx = 3'd7;
    #1;
    chk("full_merge_cycles", cyc, 8);
    chk("full_merge_total", int'(total_qty), 11);
    chk("full_merge_rd_id", int'(rd_id), 7);
    chk("full_merge_rd_qty", int'(rd_qty), 4);

    tick;
    cancel_req = 1'b1;
    tick;
    cancel_req = 1'b0;
    tick;
    tick;
    chk("shift_busy", int'(busy), 1);
    #3 RESET = 1'b1;
    #1;
    chk("midshift_count", int'(count), 0);
    chk("midshift_total", int'(total_qty), 0);
    chk("midshift_cursor", int'(cursor), 0);
    chk("midshift_busy", int'(busy), 0);
    chk("midshift_full", int'(full), 0);
    chk("midshift_rd_qty", int'(rd_qty), 0);
    chk("midshift_rd_id", int'(rd_id), 0);
    @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;

    do_cmd(OP_ADD, 3, 2, cyc, errs);
    chk("pre_clear_count", int'(count), 1);
    clear_req = 1'b1;
    add_req   = 1'b1;
    add_id    = 4'd3;
    add_qty   = 3'd2;
    tick;
    clear_req = 1'b0;
    add_req   = 1'b0;
    chk("clear_wins_busy", int'(busy), 0);
    chk("clear_wins_count", int'(count), 0);
    chk("clear_wins_total", int'(total_qty), 0);
    tick;
    chk("clear_wins_no_late_add", int'(count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
